// File: rtl/slice_store_pkg.sv
// slice_store shared types and constants.
// 64-line by 25-bit Keccak state, one 5x5 slice per line.
package slice_store_pkg;

  localparam int LINE_W = 25;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;

  typedef logic [LINE_W-1:0] slice_line_t;
  typedef logic [AW-1:0]     addr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SERVE,
    DUMP
  } state_t;

endpackage

// File: rtl/slice_store_mem.sv
// 64x25 register array, async clear.
// One write port, two combinational read ports.
module slice_store_mem
  import slice_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [LINE_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [LINE_W-1:0] rdata_b
);

  slice_line_t mem_q [DEPTH];
  slice_line_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/slice_store.sv
// Keccak state store: streaming load/dump ports plus
// a step-engine port owned while step_en is held.
module slice_store
  import slice_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [LINE_W-1:0] in_line,
  output logic              in_ready,
  output logic              load_done,
  input  logic              step_en,
  input  logic [AW-1:0]     cnt_value,
  input  logic              write_enable,
  input  logic [LINE_W-1:0] write_value,
  output logic [LINE_W-1:0] line_out,
  output logic              step_done,
  input  logic              dump_start,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_line,
  input  logic              out_ready,
  output logic              dump_done,
  output logic              busy
);

  localparam addr_t LAST = AW'(DEPTH - 1);

  state_t state_q, state_d;
  addr_t  ptr_q, ptr_d;
  logic   load_done_q, load_done_d;
  logic   step_done_q, step_done_d;
  logic   dump_done_q, dump_done_d;

  logic        we;
  addr_t       waddr;
  slice_line_t wdata;
  slice_line_t rd_cnt;
  slice_line_t rd_ptr;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    load_done_d = 1'b0;
    step_done_d = 1'b0;
    dump_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start)      state_d = LOAD;
        else if (step_en)    state_d = SERVE;
        else if (dump_start) state_d = DUMP;
      end
      LOAD: begin
        if (in_valid) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            state_d     = IDLE;
            ptr_d       = '0;
            load_done_d = 1'b1;
          end
        end
      end
      SERVE: begin
        if (!step_en) begin
          state_d     = IDLE;
          step_done_d = 1'b1;
        end
      end
      DUMP: begin
        if (out_ready) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            state_d     = IDLE;
            ptr_d       = '0;
            dump_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      load_done_q <= 1'b0;
      step_done_q <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_done_q <= load_done_d;
      step_done_q <= step_done_d;
      dump_done_q <= dump_done_d;
    end
  end

  // Only LOAD and SERVE may write; everything else is protected.
  always_comb begin
    we    = 1'b0;
    waddr = cnt_value;
    wdata = write_value;
    unique case (1'b1)
      (state_q == LOAD): begin
        we    = in_valid;
        waddr = ptr_q;
        wdata = in_line;
      end
      (state_q == SERVE): begin
        we = write_enable;
      end
      default: ;
    endcase
  end

  slice_store_mem u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (cnt_value),
    .rdata_a (rd_cnt),
    .raddr_b (ptr_q),
    .rdata_b (rd_ptr)
  );

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DUMP);
  assign busy      = (state_q != IDLE);
  assign load_done = load_done_q;
  assign step_done = step_done_q;
  assign dump_done = dump_done_q;
  assign line_out  = rd_cnt;
  assign out_line  = out_valid ? rd_ptr : '0;

endmodule
